// File: rtl/mips_debug_port_if.sv
// Host byte link, memory port and core-control signals of the MIPS32 debug port.
// The slave modport is the debug port itself; master is the host/core/memory side.
interface mips_debug_port_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              cpu_halted;

    modport slave (
        input  rx_data, rx_valid, tx_ready, mem_rdata, cpu_halted,
        output rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re,
               cpu_hold, cpu_start
    );

    modport master (
        output rx_data, rx_valid, tx_ready, mem_rdata, cpu_halted,
        input  rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re,
               cpu_hold, cpu_start
    );
endinterface

// File: rtl/mips_debug_port.sv
// Byte-serial debug/program-load responder: services W/R/G host commands against
// the core memory port, which it owns while the core is held.
module mips_debug_port #(
    parameter int ADDR_W = 10
) (
    input logic              clk1,
    input logic              rst,
    mips_debug_port_if.slave bus
);
    localparam logic [7:0] OP_W   = 8'h57;
    localparam logic [7:0] OP_R   = 8'h52;
    localparam logic [7:0] OP_G   = 8'h47;
    localparam logic [7:0] RSP_K  = 8'h4B;
    localparam logic [7:0] RSP_B  = 8'h42;
    localparam logic [7:0] RSP_UN = 8'h3F;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA, MEM_WR, MEM_RD, RD_WAIT, RESP
    } state_t;

    state_t            state_q;
    logic [7:0]        op_q;
    logic              blocked_q;
    logic [1:0]        cnt_q;
    logic [7:0]        addrHi_q;
    logic [31:0]       wdataSh_q;
    logic [31:0]       respBuf_q;
    logic              rxReady_q;
    logic              txValid_q;
    logic [7:0]        txData_q;
    logic              memWe_q;
    logic              memRe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;
    logic              cpuStart_q;
    logic              cpuHold_q;

    logic rxFire;
    logic txFire;

    assign rxFire = bus.rx_valid && rxReady_q;
    assign txFire = txValid_q && bus.tx_ready;

    assign bus.rx_ready  = rxReady_q;
    assign bus.tx_valid  = txValid_q;
    assign bus.tx_data   = txData_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_re    = memRe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.cpu_start = cpuStart_q;
    assign bus.cpu_hold  = cpuHold_q;

    // Command FSM; the blocked flag latches "core running" at opcode time so a
    // halt arriving mid-payload does not turn a refused command into a real one.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            blocked_q  <= 1'b0;
            cnt_q      <= '0;
            addrHi_q   <= '0;
            wdataSh_q  <= '0;
            respBuf_q  <= '0;
            rxReady_q  <= 1'b0;
            txValid_q  <= 1'b0;
            txData_q   <= '0;
            memWe_q    <= 1'b0;
            memRe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuStart_q <= 1'b0;
            cpuHold_q  <= 1'b1;
        end else begin
            memWe_q    <= 1'b0;
            memRe_q    <= 1'b0;
            cpuStart_q <= 1'b0;
            if (bus.cpu_halted && !cpuHold_q)
                cpuHold_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    rxReady_q <= 1'b1;
                    if (rxFire) begin
                        op_q      <= bus.rx_data;
                        blocked_q <= !cpuHold_q;
                        if (bus.rx_data == OP_W || bus.rx_data == OP_R) begin
                            state_q <= ADDR_HI;
                        end else if (bus.rx_data == OP_G) begin
                            // G reuses MEM_WR as the one-cycle gap before its reply
                            rxReady_q <= 1'b0;
                            state_q   <= MEM_WR;
                            if (cpuHold_q) begin
                                cpuStart_q <= 1'b1;
                                cpuHold_q  <= 1'b0;
                            end
                        end else begin
                            rxReady_q <= 1'b0;
                            txValid_q <= 1'b1;
                            txData_q  <= RSP_UN;
                            cnt_q     <= '0;
                            state_q   <= RESP;
                        end
                    end
                end
                ADDR_HI: begin
                    if (rxFire) begin
                        addrHi_q <= bus.rx_data;
                        state_q  <= ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (rxFire) begin
                        memAddr_q <= ADDR_W'({addrHi_q, bus.rx_data});
                        if (op_q == OP_W) begin
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            rxReady_q <= 1'b0;
                            memRe_q   <= !blocked_q;
                            state_q   <= MEM_RD;
                        end
                    end
                end
                DATA: begin
                    if (rxFire) begin
                        wdataSh_q <= {wdataSh_q[23:0], bus.rx_data};
                        cnt_q     <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            rxReady_q <= 1'b0;
                            state_q   <= MEM_WR;
                            if (!blocked_q) begin
                                memWe_q    <= 1'b1;
                                memWdata_q <= {wdataSh_q[23:0], bus.rx_data};
                            end
                        end
                    end
                end
                MEM_WR: begin
                    txValid_q <= 1'b1;
                    txData_q  <= blocked_q ? RSP_B : RSP_K;
                    cnt_q     <= '0;
                    state_q   <= RESP;
                end
                MEM_RD: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    txValid_q <= 1'b1;
                    state_q   <= RESP;
                    if (blocked_q) begin
                        txData_q <= RSP_B;
                        cnt_q    <= '0;
                    end else begin
                        txData_q  <= bus.mem_rdata[31:24];
                        respBuf_q <= {bus.mem_rdata[23:0], 8'h00};
                        cnt_q     <= 2'd3;
                    end
                end
                RESP: begin
                    if (txFire) begin
                        if (cnt_q == 2'd0) begin
                            txValid_q <= 1'b0;
                            rxReady_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            txData_q  <= respBuf_q[31:24];
                            respBuf_q <= {respBuf_q[23:0], 8'h00};
                            cnt_q     <= cnt_q - 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mips_debug_port.md
# mips_debug_port

Byte-serial debug and program-load responder for the pipelined MIPS32 core. It accepts command bytes from a host-side link and services them against the core's unified instruction/data memory: word writes (program and data load), word reads (result readback) and a go command that releases the core from hold. It sits between an external byte link (UART or JTAG bridge) and a dedicated memory port on the core, and owns that port whenever the core is held.

## Interface
- ADDR_W, 10, memory word-address width; received addresses are truncated to ADDR_W LSBs
- clk1  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  command byte from host
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte to host
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  host accepts tx_data
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  32  read data, valid the cycle after mem_re
- cpu_hold  out  1  core held; port owns memory
- cpu_start  out  1  one-cycle pulse: core restarts at PC=0 with HALTED and TAKEN_BRANCH cleared
- cpu_halted  in  1  core has executed HLT

## Operation
- Commands, all multi-byte fields big-endian:
  - 'W' (0x57), ADDR_HI, ADDR_LO, D3, D2, D1, D0: write word; response 'K' (0x4B)
  - 'R' (0x52), ADDR_HI, ADDR_LO: read word; response D3, D2, D1, D0
  - 'G' (0x47): pulse cpu_start, drop cpu_hold; response 'K'
  - Any other opcode: response '?' (0x3F); no payload consumed
- States:
  - IDLE, ADDR_HI, ADDR_LO, DATA (2-bit byte counter, 0 to 3)
  - MEM_WR, MEM_RD, RD_WAIT
  - RESP (byte counter over 1 or 4 response bytes)
- rx_ready = 1 only in IDLE, ADDR_HI, ADDR_LO and DATA. A byte advances state only on rx_valid && rx_ready.
- cpu_hold:
  - 1 from reset
  - cleared in the cycle cpu_start pulses
  - set again on the first clk1 edge where cpu_halted = 1 while cpu_hold = 0
- 'W' or 'R' received while cpu_hold = 0:
  - the full payload is still consumed
  - no mem_we or mem_re is issued
  - response is the single byte 'B' (0x42)
- 'G' while cpu_hold = 0: response 'B'; no cpu_start pulse.
- mem_wdata holds the assembled word; mem_addr holds the last received address. Both persist outside strobes.

## Timing
- Reset values:
  - rx_ready = 0, tx_valid = 0, tx_data = 0
  - mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0
  - cpu_start = 0, cpu_hold = 1
  - state IDLE
- rx_ready rises on the first edge after rst deasserts.
- Write: the cycle after D0 is accepted (MEM_WR), mem_we = 1 for exactly one cycle. The next cycle tx_valid = 1 with 'K'.
- Read:
  - the cycle after ADDR_LO is accepted: mem_re = 1 (MEM_RD)
  - next cycle (RD_WAIT): mem_rdata captured
  - next cycle: tx_valid = 1 with D3
  - latency from ADDR_LO accept to first tx_valid is 3 cycles
- 'G': the cycle after the opcode is accepted, cpu_start = 1 for one cycle and cpu_hold goes 0 the same cycle. 'K' follows the next cycle.
- Response bytes:
  - tx_data is stable while tx_valid && !tx_ready
  - the next byte is presented the cycle after acceptance; with tx_ready held high, one byte per cycle
  - after the last byte is accepted, return to IDLE next cycle
- Back-to-back: a new opcode may be accepted the cycle after return to IDLE. There is no overlap of command and response.
- cpu_halted rising during a response: cpu_hold sets without disturbing the response.
- Async rst mid-command or mid-response: immediately force the reset values. Partial payload is discarded and any pending byte is dropped.
- Address wrap: ADDR_HI:ADDR_LO >= 2^ADDR_W aliases modulo 2^ADDR_W.

## Test plan
- Write 0x00000007 to address 200, then read 200:
  - one mem_we, with mem_addr = 200 and mem_wdata = 7
  - responses 'K', then 00 00 00 07
- Load factorial program words 0x280a00c8 to 0xfc000000 at addresses 0 to 10, then send 'G':
  - eleven 'K' responses
  - single-cycle cpu_start; cpu_hold = 0
- Send 'W' to address 5 while running: payload consumed, no mem_we, response 'B'. Raise cpu_halted: cpu_hold = 1 next edge.
- After halt, read address 198 with memory returning 5040: response 00 00 13 B0.
- Edge cases:
  - opcode 0x00: response '?'
  - address 0x04C8 with ADDR_W = 10: mem_addr = 200
  - tx_ready held low for 5 cycles: tx_data stable, no byte lost
- Assert rst after 'W' and two data bytes:
  - all outputs take reset values and cpu_hold = 1
  - a subsequent full 'R' command completes normally
